// File: rtl/rs_pkg.sv
// Shared constants and types for the in-order reservation station.
package rs_pkg;
  localparam int ENT_SEL_D    = 2;
  localparam int ENT_NUM_D    = 4;
  localparam int TAG_W_D      = 6;
  localparam int MAX_DISPATCH = 2;
  localparam int CDB_NUM      = 2;

  typedef struct packed {
    logic               busy;
    logic               s1_rdy;
    logic               s2_rdy;
    logic [TAG_W_D-1:0] s1_tag;
    logic [TAG_W_D-1:0] s2_tag;
  } rs_entry_t;
endpackage

// File: rtl/rs_tag_match.sv
// Next-ready for one source operand: sticky ready, set by any valid CDB tag hit.
module rs_tag_match
  import rs_pkg::*;
#(
  parameter int TAG_W = TAG_W_D
) (
  input  logic [TAG_W-1:0]         tag,
  input  logic                     rdy,
  input  logic [CDB_NUM-1:0]       cdb_valid,
  input  logic [CDB_NUM*TAG_W-1:0] cdb_tag,
  output logic                     rdy_nxt
);
  always_comb begin
    rdy_nxt = rdy;
    for (int b = 0; b < CDB_NUM; b++)
      if (cdb_valid[b] && (cdb_tag[b*TAG_W +: TAG_W] == tag)) rdy_nxt = 1'b1;
  end
endmodule

// File: rtl/inorder_rs_entry_ctrl.sv
// Entry ring control for an in-order RS: alloc/issue pointers, occupancy,
// CDB wakeup and strictly head-only issue.
module inorder_rs_entry_ctrl
  import rs_pkg::*;
#(
  parameter int ENT_SEL = ENT_SEL_D,
  parameter int ENT_NUM = ENT_NUM_D,
  parameter int TAG_W   = TAG_W_D
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [1:0]                        dp_req_num_i,
  input  logic [MAX_DISPATCH*TAG_W-1:0]     dp_src1_tag_i,
  input  logic [MAX_DISPATCH*TAG_W-1:0]     dp_src2_tag_i,
  input  logic [MAX_DISPATCH-1:0]           dp_src1_rdy_i,
  input  logic [MAX_DISPATCH-1:0]           dp_src2_rdy_i,
  input  logic                              dp_stall_i,
  input  logic                              dp_kill_i,
  input  logic [CDB_NUM-1:0]                cdb_valid_i,
  input  logic [CDB_NUM*TAG_W-1:0]          cdb_tag_i,
  input  logic                              ex_ready_i,
  output logic                              allocatable_o,
  output logic [ENT_SEL-1:0]                alloc_ptr_o,
  output logic [ENT_SEL-1:0]                issue_ptr_o,
  output logic                              issue_valid_o,
  output logic [ENT_NUM-1:0]                busy_vector_o,
  output logic [ENT_NUM-1:0]                ready_vector_o,
  output logic [ENT_SEL:0]                  count_o
);
  logic [ENT_NUM-1:0]            busy, s1_rdy, s2_rdy, s1_wake, s2_wake;
  logic [ENT_NUM-1:0][TAG_W-1:0] s1_tag, s2_tag;
  logic [MAX_DISPATCH-1:0]       slot_s1_rdy, slot_s2_rdy;
  logic [ENT_SEL-1:0]            alloc_ptr, issue_ptr, alloc_ptr1;
  logic [ENT_SEL:0]              count, alloc_n, issue_n;
  logic [ENT_SEL+1:0]            alloc_sum;
  logic                          alloc_fire, issue_fire;

  for (genvar i = 0; i < ENT_NUM; i++) begin : g_ent
    rs_tag_match #(.TAG_W(TAG_W)) u_s1 (
      .tag(s1_tag[i]), .rdy(s1_rdy[i]), .cdb_valid(cdb_valid_i),
      .cdb_tag(cdb_tag_i), .rdy_nxt(s1_wake[i]));
    rs_tag_match #(.TAG_W(TAG_W)) u_s2 (
      .tag(s2_tag[i]), .rdy(s2_rdy[i]), .cdb_valid(cdb_valid_i),
      .cdb_tag(cdb_tag_i), .rdy_nxt(s2_wake[i]));
  end

  // Dispatch bypass: a result broadcast in the dispatch cycle marks the slot ready.
  for (genvar k = 0; k < MAX_DISPATCH; k++) begin : g_slot
    rs_tag_match #(.TAG_W(TAG_W)) u_s1 (
      .tag(dp_src1_tag_i[k*TAG_W +: TAG_W]), .rdy(dp_src1_rdy_i[k]),
      .cdb_valid(cdb_valid_i), .cdb_tag(cdb_tag_i), .rdy_nxt(slot_s1_rdy[k]));
    rs_tag_match #(.TAG_W(TAG_W)) u_s2 (
      .tag(dp_src2_tag_i[k*TAG_W +: TAG_W]), .rdy(dp_src2_rdy_i[k]),
      .cdb_valid(cdb_valid_i), .cdb_tag(cdb_tag_i), .rdy_nxt(slot_s2_rdy[k]));
  end

  // Same-cycle issue is deliberately not credited, so alloc never hits the head.
  assign alloc_sum     = (ENT_SEL+2)'(count) + (ENT_SEL+2)'(dp_req_num_i);
  assign allocatable_o = reset_i & (dp_req_num_i != 2'd3) &
                         (alloc_sum <= (ENT_SEL+2)'(ENT_NUM));
  assign alloc_fire    = allocatable_o & ~dp_stall_i & ~dp_kill_i & (dp_req_num_i != 2'd0);
  assign ready_vector_o = busy & s1_rdy & s2_rdy;
  assign issue_valid_o = ready_vector_o[issue_ptr];
  assign issue_fire    = issue_valid_o & ex_ready_i & ~dp_kill_i;
  assign alloc_n       = alloc_fire ? (ENT_SEL+1)'(dp_req_num_i) : '0;
  assign issue_n       = (ENT_SEL+1)'(issue_fire);
  assign alloc_ptr1    = alloc_ptr + 1'b1;

  assign busy_vector_o = busy;
  assign alloc_ptr_o   = alloc_ptr;
  assign issue_ptr_o   = issue_ptr;
  assign count_o       = count;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy      <= '0;
      s1_rdy    <= '0;
      s2_rdy    <= '0;
      s1_tag    <= '0;
      s2_tag    <= '0;
      alloc_ptr <= '0;
      issue_ptr <= '0;
      count     <= '0;
    end else if (dp_kill_i) begin
      busy      <= '0;
      s1_rdy    <= '0;
      s2_rdy    <= '0;
      alloc_ptr <= '0;
      issue_ptr <= '0;
      count     <= '0;
    end else begin
      s1_rdy <= s1_wake & busy;
      s2_rdy <= s2_wake & busy;
      if (issue_fire) begin
        busy[issue_ptr]   <= 1'b0;
        s1_rdy[issue_ptr] <= 1'b0;
        s2_rdy[issue_ptr] <= 1'b0;
        issue_ptr         <= issue_ptr + 1'b1;
      end
      if (alloc_fire) begin
        busy[alloc_ptr]   <= 1'b1;
        s1_rdy[alloc_ptr] <= slot_s1_rdy[0];
        s2_rdy[alloc_ptr] <= slot_s2_rdy[0];
        s1_tag[alloc_ptr] <= dp_src1_tag_i[TAG_W-1:0];
        s2_tag[alloc_ptr] <= dp_src2_tag_i[TAG_W-1:0];
        if (dp_req_num_i == 2'd2) begin
          busy[alloc_ptr1]   <= 1'b1;
          s1_rdy[alloc_ptr1] <= slot_s1_rdy[1];
          s2_rdy[alloc_ptr1] <= slot_s2_rdy[1];
          s1_tag[alloc_ptr1] <= dp_src1_tag_i[2*TAG_W-1:TAG_W];
          s2_tag[alloc_ptr1] <= dp_src2_tag_i[2*TAG_W-1:TAG_W];
        end
        alloc_ptr <= alloc_ptr + ENT_SEL'(dp_req_num_i);
      end
      count <= count + alloc_n - issue_n;
    end
  end
endmodule

// File: tb/tb_inorder_rs_entry_ctrl.sv
// Directed scenarios plus a randomized run against a queue-based RS model.
module tb_inorder_rs_entry_ctrl;
  localparam int TW = 6;

  logic            clk = 1'b0;
  logic            reset_i = 1'b0;
  logic [1:0]      dp_req_num_i = '0;
  logic [2*TW-1:0] dp_src1_tag_i = '0, dp_src2_tag_i = '0;
  logic [1:0]      dp_src1_rdy_i = '0, dp_src2_rdy_i = '0;
  logic            dp_stall_i = 1'b0, dp_kill_i = 1'b0;
  logic [1:0]      cdb_valid_i = '0;
  logic [2*TW-1:0] cdb_tag_i = '0;
  logic            ex_ready_i = 1'b0;
  logic            allocatable_o, issue_valid_o;
  logic [1:0]      alloc_ptr_o, issue_ptr_o;
  logic [3:0]      busy_vector_o, ready_vector_o;
  logic [2:0]      count_o;

  int total = 0;
  int bad = 0;

  inorder_rs_entry_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .dp_req_num_i(dp_req_num_i),
    .dp_src1_tag_i(dp_src1_tag_i), .dp_src2_tag_i(dp_src2_tag_i),
    .dp_src1_rdy_i(dp_src1_rdy_i), .dp_src2_rdy_i(dp_src2_rdy_i),
    .dp_stall_i(dp_stall_i), .dp_kill_i(dp_kill_i), .cdb_valid_i(cdb_valid_i),
    .cdb_tag_i(cdb_tag_i), .ex_ready_i(ex_ready_i), .allocatable_o(allocatable_o),
    .alloc_ptr_o(alloc_ptr_o), .issue_ptr_o(issue_ptr_o), .issue_valid_o(issue_valid_o),
    .busy_vector_o(busy_vector_o), .ready_vector_o(ready_vector_o), .count_o(count_o));

  always #5 clk = ~clk;

  task automatic idle();
    dp_req_num_i = '0; dp_src1_tag_i = '0; dp_src2_tag_i = '0;
    dp_src1_rdy_i = '0; dp_src2_rdy_i = '0; dp_stall_i = 1'b0; dp_kill_i = 1'b0;
    cdb_valid_i = '0; cdb_tag_i = '0; ex_ready_i = 1'b0;
  endtask

  task automatic drv(input logic [1:0] n, input logic [1:0] r1, input logic [1:0] r2,
                     input logic [2*TW-1:0] t1, input logic [2*TW-1:0] t2);
    dp_req_num_i = n; dp_src1_rdy_i = r1; dp_src2_rdy_i = r2;
    dp_src1_tag_i = t1; dp_src2_tag_i = t2;
  endtask

  // Leaves the bench at a negedge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk); idle(); reset_i = 1'b0;
    @(negedge clk); reset_i = 1'b1;
  endtask

  task automatic fill3();
    drv(2'd2, 2'b11, 2'b11, '0, '0);
    @(negedge clk); drv(2'd1, 2'b11, 2'b11, '0, '0);
    @(negedge clk); idle();
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); reset_i = 1'b0; dp_req_num_i = 2'd1; dp_stall_i = 1'b1;
    #1;
    total++; if (busy_vector_o !== 4'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0000", busy_vector_o); end
    total++; if (ready_vector_o !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", ready_vector_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (alloc_ptr_o !== 2'd0 || issue_ptr_o !== 2'd0) begin bad++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", alloc_ptr_o, issue_ptr_o); end
    total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL reset_iv got=%b exp=0", issue_valid_o); end
    total++; if (allocatable_o !== 1'b0) begin bad++; $display("FAIL reset_alloc got=%b exp=0", allocatable_o); end
    @(negedge clk); reset_i = 1'b1; #1;
    total++; if (allocatable_o !== 1'b1) begin bad++; $display("FAIL release_alloc got=%b exp=1", allocatable_o); end
    idle();
  endtask

  task automatic test_single_dispatch();
    do_reset();
    drv(2'd1, 2'b11, 2'b11, '0, '0); ex_ready_i = 1'b1; #1;
    total++; if (allocatable_o !== 1'b1 || alloc_ptr_o !== 2'd0) begin bad++; $display("FAIL single_pre got=%b/%0d exp=1/0", allocatable_o, alloc_ptr_o); end
    @(negedge clk); idle(); ex_ready_i = 1'b1; #1;
    total++; if (busy_vector_o !== 4'b0001) begin bad++; $display("FAIL single_busy got=%b exp=0001", busy_vector_o); end
    total++; if (issue_valid_o !== 1'b1) begin bad++; $display("FAIL single_iv got=%b exp=1", issue_valid_o); end
    total++; if (count_o !== 3'd1) begin bad++; $display("FAIL single_cnt1 got=%0d exp=1", count_o); end
    @(negedge clk); #1;
    total++; if (busy_vector_o !== 4'b0) begin bad++; $display("FAIL single_busy2 got=%b exp=0000", busy_vector_o); end
    total++; if (issue_ptr_o !== 2'd1) begin bad++; $display("FAIL single_iptr got=%0d exp=1", issue_ptr_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL single_cnt2 got=%0d exp=0", count_o); end
    idle();
  endtask

  task automatic test_fill_wrap();
    do_reset();
    drv(2'd2, 2'b11, 2'b11, '0, '0);
    @(negedge clk); drv(2'd2, 2'b11, 2'b11, '0, '0);
    @(negedge clk); drv(2'd1, 2'b11, 2'b11, '0, '0); #1;
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL full_cnt got=%0d exp=4", count_o); end
    total++; if (allocatable_o !== 1'b0) begin bad++; $display("FAIL full_alloc got=%b exp=0", allocatable_o); end
    @(negedge clk); idle(); ex_ready_i = 1'b1; #1;
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL full_refused got=%0d exp=4", count_o); end
    @(negedge clk); @(negedge clk); @(negedge clk);
    ex_ready_i = 1'b0; drv(2'd2, 2'b11, 2'b11, '0, '0); #1;
    total++; if (count_o !== 3'd1 || issue_ptr_o !== 2'd3) begin bad++; $display("FAIL drain got=%0d/%0d exp=1/3", count_o, issue_ptr_o); end
    total++; if (allocatable_o !== 1'b1 || alloc_ptr_o !== 2'd0) begin bad++; $display("FAIL wrap_pre got=%b/%0d exp=1/0", allocatable_o, alloc_ptr_o); end
    @(negedge clk); idle(); #1;
    total++; if (alloc_ptr_o !== 2'd2) begin bad++; $display("FAIL wrap_aptr got=%0d exp=2", alloc_ptr_o); end
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL wrap_cnt got=%0d exp=3", count_o); end
    total++; if (busy_vector_o !== 4'b1011) begin bad++; $display("FAIL wrap_busy got=%b exp=1011", busy_vector_o); end
    // one free entry: 1 fits, 2 does not
    dp_req_num_i = 2'd2; dp_stall_i = 1'b1; #1;
    total++; if (allocatable_o !== 1'b0) begin bad++; $display("FAIL one_free_2 got=%b exp=0", allocatable_o); end
    dp_req_num_i = 2'd1; #1;
    total++; if (allocatable_o !== 1'b1) begin bad++; $display("FAIL one_free_1 got=%b exp=1", allocatable_o); end
    dp_req_num_i = 2'd3; #1;
    total++; if (allocatable_o !== 1'b0) begin bad++; $display("FAIL illegal_req got=%b exp=0", allocatable_o); end
    idle();
  endtask

  task automatic test_wakeup_order();
    do_reset();
    drv(2'd2, 2'b10, 2'b11, {6'd0, 6'd5}, '0); ex_ready_i = 1'b1;
    @(negedge clk); idle(); ex_ready_i = 1'b1; #1;
    total++; if (busy_vector_o !== 4'b0011 || ready_vector_o !== 4'b0010) begin bad++; $display("FAIL wk_state got=%b/%b exp=0011/0010", busy_vector_o, ready_vector_o); end
    total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL wk_nonhead got=%b exp=0", issue_valid_o); end
    cdb_valid_i = 2'b10; cdb_tag_i = {6'd5, 6'd0}; #1;
    total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL wk_cycleN got=%b exp=0", issue_valid_o); end
    @(negedge clk); cdb_valid_i = '0; cdb_tag_i = '0; #1;
    total++; if (issue_valid_o !== 1'b1 || issue_ptr_o !== 2'd0) begin bad++; $display("FAIL wk_N1 got=%b/%0d exp=1/0", issue_valid_o, issue_ptr_o); end
    @(negedge clk); #1;
    total++; if (issue_ptr_o !== 2'd1 || busy_vector_o !== 4'b0010 || issue_valid_o !== 1'b1) begin bad++; $display("FAIL wk_second got=%0d/%b/%b exp=1/0010/1", issue_ptr_o, busy_vector_o, issue_valid_o); end
    @(negedge clk); #1;
    total++; if (busy_vector_o !== 4'b0 || issue_ptr_o !== 2'd2) begin bad++; $display("FAIL wk_done got=%b/%0d exp=0000/2", busy_vector_o, issue_ptr_o); end
    idle();
  endtask

  task automatic test_bypass();
    do_reset();
    drv(2'd1, 2'b00, 2'b01, {6'd0, 6'd9}, '0); cdb_valid_i = 2'b01; cdb_tag_i = {6'd0, 6'd9};
    @(negedge clk); drv(2'd1, 2'b00, 2'b01, {6'd0, 6'd10}, '0); #1;
    total++; if (ready_vector_o !== 4'b0001 || issue_valid_o !== 1'b1) begin bad++; $display("FAIL bypass_hit got=%b/%b exp=0001/1", ready_vector_o, issue_valid_o); end
    @(negedge clk); idle(); #1;
    total++; if (busy_vector_o !== 4'b0011 || ready_vector_o !== 4'b0001) begin bad++; $display("FAIL bypass_miss got=%b/%b exp=0011/0001", busy_vector_o, ready_vector_o); end
  endtask

  task automatic test_simultaneous();
    do_reset(); fill3();
    ex_ready_i = 1'b1; drv(2'd1, 2'b11, 2'b11, '0, '0); #1;
    total++; if (issue_valid_o !== 1'b1 || allocatable_o !== 1'b1) begin bad++; $display("FAIL sim_pre got=%b/%b exp=1/1", issue_valid_o, allocatable_o); end
    @(negedge clk); idle(); #1;
    total++; if (count_o !== 3'd3 || issue_ptr_o !== 2'd1 || alloc_ptr_o !== 2'd0) begin bad++; $display("FAIL sim_both got=%0d/%0d/%0d exp=3/1/0", count_o, issue_ptr_o, alloc_ptr_o); end
    total++; if (busy_vector_o !== 4'b1110) begin bad++; $display("FAIL sim_busy got=%b exp=1110", busy_vector_o); end
    do_reset(); fill3();
    ex_ready_i = 1'b1; drv(2'd1, 2'b11, 2'b11, '0, '0); dp_kill_i = 1'b1;
    @(negedge clk); idle(); #1;
    total++; if (count_o !== 3'd0 || issue_ptr_o !== 2'd0 || alloc_ptr_o !== 2'd0 || busy_vector_o !== 4'b0) begin bad++; $display("FAIL kill got=%0d/%0d/%0d/%b exp=0/0/0/0000", count_o, issue_ptr_o, alloc_ptr_o, busy_vector_o); end
  endtask

  task automatic test_async_reset();
    do_reset(); fill3(); #1;
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL ar_pre got=%0d exp=3", count_o); end
    #1 reset_i = 1'b0; #1;
    total++; if (busy_vector_o !== 4'b0 || ready_vector_o !== 4'b0 || count_o !== 3'd0) begin bad++; $display("FAIL ar_state got=%b/%b/%0d exp=0000/0000/0", busy_vector_o, ready_vector_o, count_o); end
    total++; if (alloc_ptr_o !== 2'd0 || issue_valid_o !== 1'b0 || allocatable_o !== 1'b0) begin bad++; $display("FAIL ar_out got=%0d/%b/%b exp=0/0/0", alloc_ptr_o, issue_valid_o, allocatable_o); end
    @(negedge clk); reset_i = 1'b1;
  endtask

  // Model: the RS is an ordered queue of waiting ops; slot i of the queue lives at (head+i)%4.
  typedef struct {
    bit r1, r2;
    logic [TW-1:0] t1, t2;
  } op_t;

  function automatic bit hit(logic [TW-1:0] t);
    return (cdb_valid_i[0] && cdb_tag_i[TW-1:0] == t) || (cdb_valid_i[1] && cdb_tag_i[2*TW-1:TW] == t);
  endfunction

  task automatic test_random();
    op_t q[$];
    op_t o;
    int head, tail, req;
    logic [3:0] e_busy, e_rdy;
    bit e_iv, e_alloc, iss, al;
    do_reset();
    head = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      dp_req_num_i = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        dp_src1_tag_i[k*TW +: TW] = TW'($urandom_range(0, 7));
        dp_src2_tag_i[k*TW +: TW] = TW'($urandom_range(0, 7));
        cdb_tag_i[k*TW +: TW]     = TW'($urandom_range(0, 7));
      end
      dp_src1_rdy_i = 2'($urandom); dp_src2_rdy_i = 2'($urandom);
      cdb_valid_i = 2'($urandom);
      dp_stall_i = ($urandom_range(0, 7) == 0);
      dp_kill_i  = ($urandom_range(0, 24) == 0);
      ex_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      e_busy = '0; e_rdy = '0;
      for (int k = 0; k < q.size(); k++) begin
        e_busy[(head + k) % 4] = 1'b1;
        e_rdy[(head + k) % 4] = q[k].r1 && q[k].r2;
      end
      req = int'(dp_req_num_i);
      e_iv = (q.size() > 0) && q[0].r1 && q[0].r2;
      e_alloc = (req != 3) && (q.size() + req <= 4);
      tail = (head + q.size()) % 4;
      total++; if (busy_vector_o !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", cyc, busy_vector_o, e_busy); end
      total++; if (ready_vector_o !== e_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", cyc, ready_vector_o, e_rdy); end
      total++; if (issue_valid_o !== e_iv) begin bad++; $display("FAIL rnd_iv c=%0d got=%b exp=%b", cyc, issue_valid_o, e_iv); end
      total++; if (allocatable_o !== e_alloc) begin bad++; $display("FAIL rnd_alloc c=%0d got=%b exp=%b", cyc, allocatable_o, e_alloc); end
      total++; if (int'(count_o) != q.size()) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", cyc, count_o, q.size()); end
      total++; if (int'(issue_ptr_o) != head || int'(alloc_ptr_o) != tail) begin bad++; $display("FAIL rnd_ptrs c=%0d got=%0d/%0d exp=%0d/%0d", cyc, issue_ptr_o, alloc_ptr_o, head, tail); end
      if (dp_kill_i) begin
        q.delete(); head = 0;
      end else begin
        iss = e_iv && ex_ready_i;
        al = e_alloc && !dp_stall_i && req != 0;
        for (int k = 0; k < q.size(); k++) begin
          if (hit(q[k].t1)) q[k].r1 = 1'b1;
          if (hit(q[k].t2)) q[k].r2 = 1'b1;
        end
        if (iss) begin void'(q.pop_front()); head = (head + 1) % 4; end
        if (al)
          for (int k = 0; k < req; k++) begin
            o.t1 = dp_src1_tag_i[k*TW +: TW]; o.t2 = dp_src2_tag_i[k*TW +: TW];
            o.r1 = dp_src1_rdy_i[k] || hit(o.t1);
            o.r2 = dp_src2_rdy_i[k] || hit(o.t2);
            q.push_back(o);
          end
      end
    end
    @(negedge clk); idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_dispatch();
    test_fill_wrap();
    test_wakeup_order();
    test_bypass();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
